mfcc_core: RTL and testbench
============================

// Module: mfcc_core
// PURPOSE
//  Front end of the MFCC pipeline. Buffers incoming PCM samples in a FIFO and
//  applies first-order pre-emphasis. Slices the stream into overlapping frames
//  and emits each frame as a zero-padded FFT_SIZE-sample stream to the FFT stage.
//  Windowing, FFT, mel filtering and DCT are downstream blocks.
// PARAMETERS
//  SAMPLE_WIDTH      16     PCM sample width, signed two's complement
//  NUM_COEFFICIENTS  12     cepstral coefficient count; exported to downstream stages, unused here
//  NUM_FILTERS       40     mel filter count; exported to downstream stages, unused here
//  FRAME_SIZE        400    samples per frame (must be <= FFT_SIZE)
//  FRAME_MOVE        160    hop between frame starts, in samples (must be <= FRAME_SIZE)
//  FFT_SIZE          512    words emitted per frame, including zero padding
//  PCM_FIFO_DEPTH    256    input FIFO depth in samples (power of 2)
//  ALPHA             31785  pre-emphasis coefficient, unsigned Q1.15 (0.97)
// PORTS
//  clk            in   1             single clock, rising edge
//  rst_n          in   1             reset: synchronous, ACTIVE-HIGH (1 = reset, despite the name)
//  pcm_in         in   SAMPLE_WIDTH  PCM sample, signed
//  pcm_ready_i    in   1             pcm_in is valid this cycle; no backpressure toward the source
//  frame_data_o   out  SAMPLE_WIDTH  pre-emphasized sample or padding zero
//  frame_valid_o  out  1             frame_data_o is valid
//  frame_ready_i  in   1             downstream accepts the word (transfer = valid & ready)
//  frame_first_o  out  1             marks word 0 of a frame
//  frame_last_o   out  1             marks word FFT_SIZE-1 of a frame
//  overflow_o     out  1             sticky: a sample was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (rst_n=1 at posedge):
//   - All outputs go to 0.
//   - FIFO is emptied, x_prev=0, frame buffer write count=0, state=FILL.
//   - Reset in the middle of a frame aborts it; frame_valid_o is 0 on the next cycle.
//  Input FIFO:
//   - pcm_ready_i=1 writes pcm_in. The word is readable on the next cycle.
//   - Writing while full drops the sample and sets overflow_o, which stays set until reset.
//   - A simultaneous read and write while full is accepted.
//  Pre-emphasis (applied on each FIFO pop):
//   - y = x - ((ALPHA*x_prev) >>> 15), using an arithmetic shift (floor).
//   - Compute in 33-bit signed, then saturate to [-32768, 32767].
//   - x_prev <= x after each pop; the first sample after reset uses x_prev=0.
//  Frame buffer:
//   - Circular RAM of FRAME_SIZE words; the write pointer wraps FRAME_SIZE-1 -> 0.
//   - new_cnt counts samples stored since the last frame trigger.
//  States:
//   - FILL: pop one sample per cycle when the FIFO is non-empty. Go to EMIT when
//     the total stored reaches FRAME_SIZE (first frame) or new_cnt reaches FRAME_MOVE (later frames).
//   - EMIT: no FIFO pops; the FIFO keeps absorbing input.
//     Words 0..FRAME_SIZE-1 are read from the buffer starting at the oldest sample (= write pointer).
//     Words FRAME_SIZE..FFT_SIZE-1 are 0.
//     Advance only on valid&ready; hold data and flags while valid & !ready.
//     After the transfer of the last word, clear new_cnt and return to FILL.
//  Frame k covers pre-emphasized samples k*FRAME_MOVE .. k*FRAME_MOVE+FRAME_SIZE-1.
//  frame_first_o and frame_last_o are only meaningful while frame_valid_o=1.
//  Latency: the first word of a frame appears <= 3 cycles after the triggering sample is popped.
// TESTING
//  1. Constant input 1000 x 400, ready=1:
//     -> frame 0 word0 = 1000, words 1..399 = 30, words 400..511 = 0;
//     -> first on word 0, last on word 511.
//  2. Samples 32767 then -32768:
//     -> second output saturates to -32768 (unsaturated value -64552).
//  3. Ramp 0..559 with ready=1:
//     -> frame 0 starts with the sample derived from input 0;
//     -> frame 1 (emitted after sample 559 is stored) starts at input 160 and holds 400 words plus zero padding.
//  4. Toggle frame_ready_i low for random cycles during a frame:
//     -> no word is lost or duplicated; data and flags stay stable while stalled.
//  5. frame_ready_i=0 and 300 pushes:
//     -> FIFO holds 256 samples, overflow_o=1, the remaining samples are dropped.
//  6. Assert rst_n for 1 cycle at word 200:
//     -> frame_valid_o=0 and overflow_o=0 on the next cycle;
//     -> the next frame needs 400 fresh samples.

Source files
------------

// File: rtl/mfcc_core.sv
// mfcc_core: MFCC front end. PCM FIFO, first-order pre-emphasis, overlapping
// framing, and a zero-padded FFT_SIZE-word stream per frame to the FFT stage.
// Ports: clk; rst_n (synchronous, active-high); pcm_in/pcm_ready_i sample input
//   (no backpressure); frame_data_o/frame_valid_o/frame_ready_i stream with
//   frame_first_o/frame_last_o markers; overflow_o sticky sample-drop flag.
module mfcc_core #(
    parameter int SAMPLE_WIDTH     = 16,
    parameter int NUM_COEFFICIENTS = 12,
    parameter int NUM_FILTERS      = 40,
    parameter int FRAME_SIZE       = 400,
    parameter int FRAME_MOVE       = 160,
    parameter int FFT_SIZE         = 512,
    parameter int PCM_FIFO_DEPTH   = 256,
    parameter int ALPHA            = 31785
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SAMPLE_WIDTH-1:0] pcm_in,
    input  logic                    pcm_ready_i,
    output logic [SAMPLE_WIDTH-1:0] frame_data_o,
    output logic                    frame_valid_o,
    input  logic                    frame_ready_i,
    output logic                    frame_first_o,
    output logic                    frame_last_o,
    output logic                    overflow_o
);

    localparam int SW   = SAMPLE_WIDTH;
    localparam int FA_W = $clog2(PCM_FIFO_DEPTH);
    localparam int FC_W = FA_W + 1;
    localparam int BP_W = $clog2(FRAME_SIZE);
    localparam int NC_W = $clog2(FRAME_SIZE + 1);
    localparam int WI_W = $clog2(FFT_SIZE + 1);
    localparam int RA_W = $clog2(FRAME_SIZE + FFT_SIZE);

    localparam logic signed [32:0] ALPHA_S = 33'(ALPHA);
    localparam logic signed [32:0] SAT_HI  = 33'((1 << (SW - 1)) - 1);
    localparam logic signed [32:0] SAT_LO  = -SAT_HI - 33'sd1;

    // The cepstral sizes only travel with the pipeline; they are sanity
    // checked here together with the framing geometry.
    if (NUM_COEFFICIENTS < 1 || NUM_FILTERS < NUM_COEFFICIENTS ||
        FRAME_SIZE > FFT_SIZE || FRAME_MOVE > FRAME_SIZE ||
        FRAME_MOVE < 1) begin : g_bad_params
        $error("mfcc_core: inconsistent parameters");
    end

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Input FIFO
    logic signed [SW-1:0] fifo_mem [PCM_FIFO_DEPTH];
    logic [FA_W-1:0] fifo_wr_q, fifo_wr_d;
    logic [FA_W-1:0] fifo_rd_q, fifo_rd_d;
    logic [FC_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic            fifo_empty, fifo_full;
    logic            fifo_pop, fifo_push;

    // Pre-emphasis
    logic signed [SW-1:0] x_cur;
    logic signed [SW-1:0] x_prev_q, x_prev_d;
    logic signed [32:0]   x_ext, xp_ext, prod, diff;
    logic signed [SW-1:0] y;

    // Frame buffer and emit sequencing
    logic signed [SW-1:0] fbuf [FRAME_SIZE];
    logic [BP_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [NC_W-1:0] new_cnt_q, new_cnt_d;
    logic [NC_W-1:0] new_cnt_inc, target;
    logic            primed_q, primed_d;
    logic [WI_W-1:0] widx_q, widx_d;
    logic [RA_W-1:0] rd_sum;
    logic [BP_W-1:0] rd_addr;
    logic            in_frame, last_word, xfer, trigger;
    logic            overflow_q, overflow_d;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == FC_W'(PCM_FIFO_DEPTH));
    assign fifo_pop   = (state_q == FILL) && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign fifo_push  = pcm_ready_i && (!fifo_full || fifo_pop);

    assign x_cur = fifo_mem[fifo_rd_q];

    always_comb begin
        x_ext  = {{(33 - SW){x_cur[SW-1]}}, x_cur};
        xp_ext = {{(33 - SW){x_prev_q[SW-1]}}, x_prev_q};
        prod   = ALPHA_S * xp_ext;
        diff   = x_ext - (prod >>> 15);
        if (diff > SAT_HI) begin
            y = SW'(SAT_HI);
        end else if (diff < SAT_LO) begin
            y = SW'(SAT_LO);
        end else begin
            y = diff[SW-1:0];
        end
    end

    assign new_cnt_inc = new_cnt_q + NC_W'(1);
    // The first frame needs a full buffer; later ones only a hop.
    assign target      = primed_q ? NC_W'(FRAME_MOVE) : NC_W'(FRAME_SIZE);
    assign trigger     = fifo_pop && (new_cnt_inc == target);

    assign in_frame    = (widx_q < WI_W'(FRAME_SIZE));
    assign last_word   = (widx_q == WI_W'(FFT_SIZE - 1));
    assign xfer        = (state_q == EMIT) && frame_ready_i;

    // The oldest sample sits at the write pointer; walk forward with wrap.
    always_comb begin
        rd_sum  = RA_W'(wr_ptr_q) + RA_W'(widx_q);
        rd_addr = BP_W'((rd_sum >= RA_W'(FRAME_SIZE)) ?
                        rd_sum - RA_W'(FRAME_SIZE) : rd_sum);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: if (trigger) state_d = EMIT;
            EMIT: if (xfer && last_word) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Datapath next values
    always_comb begin
        fifo_wr_d  = fifo_push ? fifo_wr_q + FA_W'(1) : fifo_wr_q;
        fifo_rd_d  = fifo_pop ? fifo_rd_q + FA_W'(1) : fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q + FC_W'(fifo_push) - FC_W'(fifo_pop);
        overflow_d = overflow_q || (pcm_ready_i && fifo_full && !fifo_pop);
        x_prev_d   = fifo_pop ? x_cur : x_prev_q;
        wr_ptr_d   = wr_ptr_q;
        new_cnt_d  = new_cnt_q;
        primed_d   = primed_q || trigger;
        widx_d     = widx_q;
        if (fifo_pop) begin
            wr_ptr_d  = (wr_ptr_q == BP_W'(FRAME_SIZE - 1)) ?
                        '0 : wr_ptr_q + BP_W'(1);
            new_cnt_d = new_cnt_inc;
        end
        if (xfer) begin
            widx_d = last_word ? '0 : widx_q + WI_W'(1);
            if (last_word) begin
                new_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
            overflow_q <= 1'b0;
            x_prev_q   <= '0;
            wr_ptr_q   <= '0;
            new_cnt_q  <= '0;
            primed_q   <= 1'b0;
            widx_q     <= '0;
        end else begin
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
            overflow_q <= overflow_d;
            x_prev_q   <= x_prev_d;
            wr_ptr_q   <= wr_ptr_d;
            new_cnt_q  <= new_cnt_d;
            primed_q   <= primed_d;
            widx_q     <= widx_d;
        end
    end

    // Storage arrays carry no reset; pointers define their contents.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[fifo_wr_q] <= pcm_in;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_pop) begin
            fbuf[wr_ptr_q] <= y;
        end
    end

    // Outputs come straight from registered state, so they hold while stalled.
    always_comb begin
        frame_valid_o = (state_q == EMIT);
        frame_data_o  = '0;
        frame_first_o = 1'b0;
        frame_last_o  = 1'b0;
        overflow_o    = overflow_q;
        if (state_q == EMIT) begin
            frame_data_o  = in_frame ? fbuf[rd_addr] : '0;
            frame_first_o = (widx_q == '0);
            frame_last_o  = last_word;
        end
    end

endmodule

// File: tb/tb_mfcc_core.sv
// tb_mfcc_core: directed + randomized checks of mfcc_core against a
// sample-level model of pre-emphasis and overlapping framing.
module tb_mfcc_core;

    localparam int FS  = 400;
    localparam int FM  = 160;
    localparam int FFT = 512;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] pcm_in = '0;
    logic        pcm_ready_i = 1'b0;
    logic        frame_ready_i = 1'b0;
    logic [15:0] frame_data_o;
    logic        frame_valid_o;
    logic        frame_first_o;
    logic        frame_last_o;
    logic        overflow_o;

    always #5 clk = ~clk;

    mfcc_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pcm_in       (pcm_in),
        .pcm_ready_i  (pcm_ready_i),
        .frame_data_o (frame_data_o),
        .frame_valid_o(frame_valid_o),
        .frame_ready_i(frame_ready_i),
        .frame_first_o(frame_first_o),
        .frame_last_o (frame_last_o),
        .overflow_o   (overflow_o)
    );

    int n_vec = 0;
    int n_bad = 0;
    int stall_pct = 0;
    logic [17:0] q[$];
    int ymod[$];
    int xprev_m = 0;
    logic hold_chk = 1'b0;
    logic [18:0] hold_v = '0;

    always @(negedge clk) begin
        if (hold_chk) begin
            n_vec++;
            assert ({frame_valid_o, frame_data_o, frame_first_o,
                     frame_last_o} === hold_v)
            else begin
                n_bad++;
                $error("FAIL stall_hold: got %h want %h",
                       {frame_valid_o, frame_data_o, frame_first_o,
                        frame_last_o}, hold_v);
            end
        end
        hold_chk <= frame_valid_o && !frame_ready_i && !rst_n;
        hold_v <= {frame_valid_o, frame_data_o, frame_first_o, frame_last_o};
        if (frame_valid_o && frame_ready_i)
            q.push_back({frame_data_o, frame_first_o, frame_last_o});
    end

    function automatic int pre(int x, int xp);
        longint p, s, yv;
        p = longint'(31785) * longint'(xp);
        if (p >= 0) s = p / 32768;
        else s = -((-p + 32767) / 32768);
        yv = longint'(x) - s;
        if (yv > 32767) yv = 32767;
        if (yv < -32768) yv = -32768;
        return int'(yv);
    endfunction

    function automatic int wd(int i);
        logic [17:0] e;
        e = q[i];
        return int'($signed(e[17:2]));
    endfunction

    function automatic int wf(int i);
        logic [17:0] e;
        e = q[i];
        return int'(e[1]);
    endfunction

    function automatic int wl(int i);
        logic [17:0] e;
        e = q[i];
        return int'(e[0]);
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d);
        pcm_ready_i = v;
        pcm_in = d;
        frame_ready_i = (int'($urandom_range(99)) >= stall_pct);
        @(posedge clk);
        #1;
        pcm_ready_i = 1'b0;
    endtask

    task automatic push(input int x);
        step(1'b1, 16'(x));
        ymod.push_back(pre(x, xprev_m));
        xprev_m = x;
    endtask

    task automatic model_clear();
        ymod.delete();
        xprev_m = 0;
        q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        step(1'b0, '0);
        step(1'b0, '0);
        rst_n = 1'b0;
        model_clear();
    endtask

    task automatic wait_words(input int n, input int budget);
        int c;
        c = 0;
        while (q.size() < n && c < budget) begin
            step(1'b0, '0);
            c++;
        end
        chk("word_count_timeout", (q.size() >= n) ? 1 : 0, 1);
    endtask

    task automatic check_frame(input int k);
        logic [17:0] got, exp;
        int e;
        for (int j = 0; j < FFT; j++) begin
            e = (j < FS) ? ymod[k * FM + j] : 0;
            exp = {16'(e), j == 0, j == FFT - 1};
            got = (q.size() > 0) ? q.pop_front() : 'x;
            n_vec++;
            assert (got === exp)
            else begin
                n_bad++;
                $error("FAIL frame%0d_word%0d: got d=%0d f=%b l=%b want d=%0d f=%b l=%b",
                       k, j, $signed(got[17:2]), got[1], got[0],
                       $signed(exp[17:2]), exp[1], exp[0]);
            end
        end
    endtask

    initial begin
        int x0;
        int c;

        // Reset state
        step(1'b0, '0);
        step(1'b0, '0);
        chk("rst_valid", int'(frame_valid_o), 0);
        chk("rst_data", int'(frame_data_o), 0);
        chk("rst_first", int'(frame_first_o), 0);
        chk("rst_last", int'(frame_last_o), 0);
        chk("rst_ovf", int'(overflow_o), 0);
        rst_n = 1'b0;
        model_clear();

        // Constant input
        stall_pct = 0;
        for (int i = 0; i < FS; i++) push(1000);
        wait_words(FFT, 3000);
        chk("const_w0", wd(0), 1000);
        chk("const_w0_first", wf(0), 1);
        chk("const_w1", wd(1), 30);
        chk("const_w399", wd(399), 30);
        chk("const_w400", wd(400), 0);
        chk("const_w511_last", wl(511), 1);
        chk("const_w510_last", wl(510), 0);
        check_frame(0);
        step(1'b0, '0);
        chk("const_idle_valid", int'(frame_valid_o), 0);

        // Saturation
        do_reset();
        push(32767);
        push(-32768);
        for (int i = 2; i < FS; i++) push(rnd16());
        wait_words(FFT, 3000);
        chk("sat_w0", wd(0), 32767);
        chk("sat_w1", wd(1), -32768);
        check_frame(0);

        // Ramp, two overlapping frames
        do_reset();
        for (int i = 0; i < FS + FM; i++) push(i);
        wait_words(2 * FFT, 4000);
        chk("ramp_f0w0", wd(0), 0);
        chk("ramp_f1w0", wd(FFT), 6);
        chk("ramp_f1_first", wf(FFT), 1);
        check_frame(0);
        check_frame(1);
        for (int i = 0; i < 50; i++) step(1'b0, '0);
        chk("ramp_no_f2", q.size(), 0);

        // Random data with random downstream stalls
        do_reset();
        stall_pct = 40;
        for (int i = 0; i < FS + FM; i++) push(rnd16());
        wait_words(2 * FFT, 6000);
        check_frame(0);
        check_frame(1);
        chk("stall_ovf", int'(overflow_o), 0);

        // FIFO overflow while downstream is blocked
        do_reset();
        stall_pct = 100;
        for (int i = 0; i < FS; i++) push(rnd16());
        c = 0;
        while (!frame_valid_o && c < 20) begin
            step(1'b0, '0);
            c++;
        end
        chk("ovf_emit_start", int'(frame_valid_o), 1);
        for (int i = 0; i < 300; i++) begin
            if (i < 256) push(rnd16());
            else step(1'b1, 16'($urandom_range(65535)));
        end
        for (int i = 0; i < 5; i++) step(1'b0, '0);
        chk("ovf_flag", int'(overflow_o), 1);
        chk("ovf_no_xfer", q.size(), 0);
        chk("ovf_hold_first", int'(frame_first_o), 1);
        stall_pct = 0;
        wait_words(2 * FFT, 4000);
        check_frame(0);
        check_frame(1);
        for (int i = 0; i < 600; i++) step(1'b0, '0);
        chk("ovf_no_f2", q.size(), 0);
        chk("ovf_sticky", int'(overflow_o), 1);

        // Reset in the middle of a frame
        do_reset();
        stall_pct = 0;
        for (int i = 0; i < FS; i++) push(rnd16());
        wait_words(200, 1000);
        stall_pct = 100;
        for (int i = 0; i < 300; i++) step(1'b1, 16'($urandom_range(65535)));
        chk("mid_ovf_set", int'(overflow_o), 1);
        rst_n = 1'b1;
        step(1'b0, '0);
        rst_n = 1'b0;
        chk("mid_rst_valid", int'(frame_valid_o), 0);
        chk("mid_rst_ovf", int'(overflow_o), 0);
        model_clear();
        stall_pct = 0;
        x0 = rnd16();
        push(x0);
        for (int i = 1; i < FS - 1; i++) push(rnd16());
        for (int i = 0; i < 30; i++) step(1'b0, '0);
        chk("mid_399_nofr", q.size(), 0);
        chk("mid_399_valid", int'(frame_valid_o), 0);
        push(rnd16());
        wait_words(FFT, 3000);
        chk("mid_fresh_w0", wd(0), x0);
        check_frame(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
